// File: rtl/seg7_msg_sched.sv
// seg7_msg_sched: round-robin arbiter between two 8-character ASCII message
// requesters, sequencing the granted message into the seg7x8 write port one
// digit per WRITE_GAP-cycle slot and acknowledging when all 8 are written.
// Optional build macro SEG7_SKIP_UNCHANGED_EN: suppress writes whose byte
// already matches the last value written to that digit (slot still consumed).
module seg7_msg_sched #(
    parameter int WRITE_GAP = 1          // cycles per write slot, >= 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [63:0] msg0_i,
    input  logic [63:0] msg1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic        busy_o,
    output logic        wr_en_o,
    output logic [2:0]  wr_id_o,
    output logic [7:0]  wr_ascii_o
);

    localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(WRITE_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [63:0]   buf_q, buf_d;
    logic [2:0]    idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          grant_q, grant_d;     // requester currently being served
    logic          last_q, last_d;       // requester served most recently
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [2:0]    wr_id_q, wr_id_d;
    logic [7:0]    wr_ascii_q, wr_ascii_d;

    logic          issue;                // a write slot starts on this edge
    logic [2:0]    issue_id;
    logic [7:0]    issue_byte;
    logic          pick;
    logic [2:0]    idx_next;

    assign idx_next = idx_q + 3'd1;

`ifdef SEG7_SKIP_UNCHANGED_EN
    logic [7:0] shadow_q [8];
    logic [7:0] valid_q;

    // Remember the last byte actually written to each digit.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < 8; i++) shadow_q[i] <= 8'h00;
        end else if (wr_en_d) begin
            valid_q[wr_id_d]  <= 1'b1;
            shadow_q[wr_id_d] <= wr_ascii_d;
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            idx_q      <= 3'd0;
            gap_q      <= '0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_id_q    <= 3'd0;
            wr_ascii_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_id_q    <= wr_id_d;
            wr_ascii_q <= wr_ascii_d;
        end
    end

    // Next-state: arbitration, slot sequencing and write-port values.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        grant_d    = grant_q;
        last_d     = last_q;
        busy_d     = busy_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        issue      = 1'b0;
        issue_id   = 3'd0;
        issue_byte = 8'h00;
        pick       = 1'b0;
        wr_en_d    = 1'b0;
        wr_id_d    = wr_id_q;
        wr_ascii_d = wr_ascii_q;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    // On a tie, serve whichever was not served last.
                    pick       = (req0_i && req1_i) ? ~last_q : req1_i;
                    grant_d    = pick;
                    buf_d      = pick ? msg1_i : msg0_i;
                    idx_d      = 3'd0;
                    gap_d      = '0;
                    state_d    = S_WRITE;
                    busy_d     = 1'b1;
                    issue      = 1'b1;
                    issue_id   = 3'd0;
                    issue_byte = pick ? msg1_i[7:0] : msg0_i[7:0];
                end
            end
            S_WRITE: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_DONE;
                        ack0_d  = ~grant_q;
                        ack1_d  = grant_q;
                    end else begin
                        idx_d      = idx_next;
                        issue      = 1'b1;
                        issue_id   = idx_next;
                        issue_byte = buf_q[{idx_next, 3'b000} +: 8];
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                last_d  = grant_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (issue) begin
            wr_id_d    = issue_id;
            wr_ascii_d = issue_byte;
`ifdef SEG7_SKIP_UNCHANGED_EN
            wr_en_d    = ~(valid_q[issue_id] && (shadow_q[issue_id] == issue_byte));
`else
            wr_en_d    = 1'b1;
`endif
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign busy_o     = busy_q;
    assign wr_en_o    = wr_en_q;
    assign wr_id_o    = wr_id_q;
    assign wr_ascii_o = wr_ascii_q;

endmodule
